// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit map, syndrome and encode helpers.
// Intended to be used by both the decoder and the future encoder.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam logic [2:0] NO_ERR_POS = 3'd7;

  localparam int unsigned D3_IDX = 0;
  localparam int unsigned D2_IDX = 1;
  localparam int unsigned D1_IDX = 2;
  localparam int unsigned P4_IDX = 3;
  localparam int unsigned D0_IDX = 4;
  localparam int unsigned P2_IDX = 5;
  localparam int unsigned P1_IDX = 6;

  // Result is {S4,S2,S1}; a single error at bit i yields 7-i.
  function automatic logic [2:0] syndrome(input logic [CODE_W-1:0] code);
    logic s1, s2, s4;
    s1 = code[P1_IDX] ^ code[D3_IDX] ^ code[D1_IDX] ^ code[D0_IDX];
    s2 = code[P2_IDX] ^ code[D3_IDX] ^ code[D2_IDX] ^ code[D0_IDX];
    s4 = code[P4_IDX] ^ code[D3_IDX] ^ code[D2_IDX] ^ code[D1_IDX];
    return {s4, s2, s1};
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[D3_IDX] = data[3];
    c[D2_IDX] = data[2];
    c[D1_IDX] = data[1];
    c[D0_IDX] = data[0];
    c[P1_IDX] = c[D3_IDX] ^ c[D1_IDX] ^ c[D0_IDX];
    c[P2_IDX] = c[D3_IDX] ^ c[D2_IDX] ^ c[D0_IDX];
    c[P4_IDX] = c[D3_IDX] ^ c[D2_IDX] ^ c[D1_IDX];
    return c;
  endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) check: syndrome, single-bit correction and data extraction.
module hamming74_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [2:0]        syn,
  output logic [CODE_W-1:0] corrected,
  output logic [DATA_W-1:0] data
);

  logic [CODE_W-1:0] flip_mask;

  always_comb begin
    syn       = syndrome(code);
    flip_mask = '0;
    if (syn != '0) flip_mask = CODE_W'(1) << (3'd7 - syn);
    corrected = code ^ flip_mask;
    data      = {corrected[D3_IDX], corrected[D2_IDX], corrected[D1_IDX], corrected[D0_IDX]};
  end

endmodule

// File: rtl/hamming74_decoder.sv
// Two-stage streaming Hamming(7,4) decoder with valid/ready on both sides
// and saturating clean/corrected word counters.
module hamming74_decoder
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_data,
  output logic               out_corrected,
  output logic [2:0]         out_err_pos,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   clean_cnt,
  output logic [CNT_W-1:0]   corr_cnt
);

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [2:0]        s1_syn;
  logic              s2_can_accept;
  logic              out_fire;

  logic [2:0]        dec_syn;
  logic [CODE_W-1:0] dec_corrected;
  logic [DATA_W-1:0] dec_data;

  assign s2_can_accept = !out_valid || out_ready;
  assign in_ready      = !s1_valid || s2_can_accept;
  assign out_fire      = out_valid && out_ready;

  hamming74_syndrome u_syndrome (
    .code      (s1_code),
    .syn       (dec_syn),
    .corrected (dec_corrected),
    .data      (dec_data)
  );

  // Correction always lands on a zero-syndrome word, even for miscorrected doubles.
  always_comb begin
    if (s1_valid) begin
      assert (dec_syn == s1_syn && syndrome(dec_corrected) == 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_code <= in_code;
      s1_syn  <= syndrome(in_code);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_err_pos   <= NO_ERR_POS;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_can_accept) out_valid <= s1_valid;
      if (s2_can_accept && s1_valid) begin
        out_data      <= dec_data;
        out_corrected <= (s1_syn != 3'd0);
        out_err_pos   <= (s1_syn != 3'd0) ? 3'd7 - s1_syn : NO_ERR_POS;
      end
    end
  end

  // Clear wins over an increment on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      clean_cnt <= '0;
      corr_cnt  <= '0;
    end else if (out_fire) begin
      if (!out_corrected) begin
        if (clean_cnt != '1) clean_cnt <= clean_cnt + 1'b1;
      end else begin
        if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming74_decoder.sv
// Scoreboard bench for hamming74_decoder: expected words are queued on input
// handshake and compared on output handshake; counters tracked by a small model.
module tb_hamming74_decoder;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic             out_corrected;
  logic [2:0]       out_err_pos;
  logic             cnt_clr;
  logic [CNT_W-1:0] clean_cnt;
  logic [CNT_W-1:0] corr_cnt;

  typedef struct packed {
    logic [3:0] d;
    logic       cor;
    logic [2:0] pos;
  } exp_t;

  exp_t             q[$];
  exp_t             drv_exp;
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] m_clean = '0;
  logic [CNT_W-1:0] m_corr = '0;
  bit               rst_seen = 1'b0;

  hamming74_decoder #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_corrected (out_corrected),
    .out_err_pos   (out_err_pos),
    .cnt_clr       (cnt_clr),
    .clean_cnt     (clean_cnt),
    .corr_cnt      (corr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] encode_ref(input logic [3:0] d);
    logic [6:0] c;
    c    = '0;
    c[0] = d[3];
    c[1] = d[2];
    c[2] = d[1];
    c[4] = d[0];
    c[6] = c[0] ^ c[2] ^ c[4];
    c[5] = c[0] ^ c[1] ^ c[4];
    c[3] = c[0] ^ c[1] ^ c[2];
    return c;
  endfunction

  // Monitor: counter model check every cycle, scoreboard pop/push on handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_clean  = '0;
      m_corr   = '0;
      rst_seen = 1'b1;
    end else if (rst_seen) begin
      checks++;
      if (clean_cnt !== m_clean) begin
        errors++;
        $display("FAIL clean_cnt: got %0d expected %0d at %0t", clean_cnt, m_clean, $time);
      end
      checks++;
      if (corr_cnt !== m_corr) begin
        errors++;
        $display("FAIL corr_cnt: got %0d expected %0d at %0t", corr_cnt, m_corr, $time);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: data=%h with empty scoreboard at %0t", out_data, $time);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_corrected !== e.cor || out_err_pos !== e.pos) begin
            errors++;
            $display("FAIL out_word: got data=%h cor=%b pos=%0d expected data=%h cor=%b pos=%0d at %0t",
                     out_data, out_corrected, out_err_pos, e.d, e.cor, e.pos, $time);
          end
          if (e.cor) begin
            if (m_corr != '1) m_corr = m_corr + 1'b1;
          end else begin
            if (m_clean != '1) m_clean = m_clean + 1'b1;
          end
        end
      end
      if (cnt_clr) begin
        m_clean = '0;
        m_corr  = '0;
      end
      if (in_valid && in_ready) q.push_back(drv_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flip < 0 sends a clean codeword
  task automatic set_word(input logic [3:0] d, input int flip);
    logic [6:0] c;
    c = encode_ref(d);
    if (flip >= 0) c[flip[2:0]] = ~c[flip[2:0]];
    in_valid = 1'b1;
    in_code  = c;
    drv_exp  = '{d: d, cor: (flip >= 0), pos: (flip >= 0) ? 3'(flip) : 3'd7};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    drv_exp = '0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_corrected !== 1'b0 ||
        out_err_pos !== 3'd7 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h c=%b pos=%0d rdy=%b expected 0 0 0 7 1",
               out_valid, out_data, out_corrected, out_err_pos, in_ready);
    end
  endtask

  task automatic test_clean();
    tick();
    in_valid = 1'b1; in_code = 7'h55; drv_exp = '{d: 4'b1011, cor: 1'b0, pos: 3'd7};
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_latency1: out_valid=%b expected 0", out_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_corrected !== 1'b0 || out_err_pos !== 3'd7) begin
      errors++;
      $display("FAIL clean_word: got v=%b d=%b c=%b pos=%0d expected 1 1011 0 7",
               out_valid, out_data, out_corrected, out_err_pos);
    end
    tick();
    @(negedge clk);
    checks++;
    if (clean_cnt !== 2'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_count: got cnt=%0d v=%b expected 1 0", clean_cnt, out_valid);
    end
  endtask

  task automatic test_single_error();
    tick();
    in_valid = 1'b1; in_code = 7'h51; drv_exp = '{d: 4'b1011, cor: 1'b1, pos: 3'd2};
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_corrected !== 1'b1 || out_err_pos !== 3'd2) begin
      errors++;
      $display("FAIL single_err: got v=%b d=%b c=%b pos=%0d expected 1 1011 1 2",
               out_valid, out_data, out_corrected, out_err_pos);
    end
    tick();
    @(negedge clk);
    checks++;
    if (corr_cnt !== 2'd1) begin
      errors++;
      $display("FAIL single_count: corr_cnt=%0d expected 1", corr_cnt);
    end
    for (int k = 0; k < 7; k++) begin
      set_word(4'hF, k);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (corr_cnt !== 2'd3 || q.size() != 0) begin
      errors++;
      $display("FAIL sweep_saturate: corr_cnt=%0d pending=%0d expected 3 0", corr_cnt, q.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad_rdy = 0;
    int bad_v = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i < 16) set_word(4'(i), -1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_ready !== 1'b1) bad_rdy++;
      if (out_valid !== (i >= 2 && i <= 17)) bad_v++;
    end
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL b2b_in_ready: dropped %0d times expected 0", bad_rdy);
    end
    checks++;
    if (bad_v != 0 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_stream: %0d gaps, %0d pending expected 0 0", bad_v, q.size());
    end
  endtask

  task automatic test_backpressure();
    int   k = 0;
    logic held = 1'b0;
    logic [7:0] saved = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (k < 8) set_word(4'(k + 4), k - 1);
      else in_valid = 1'b0;
      out_ready = !(cyc >= 3 && cyc < 8);
      @(negedge clk);
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {out_data, out_corrected, out_err_pos} !== saved) begin
          errors++;
          $display("FAIL bp_stable: got v=%b %h expected 1 %h at cyc %0d",
                   out_valid, {out_data, out_corrected, out_err_pos}, saved, cyc);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: in_ready=%b expected 0 with both stages held", in_ready);
        end
      end
      held  = out_valid && !out_ready;
      saved = {out_data, out_corrected, out_err_pos};
      if (in_valid && in_ready) k++;
    end
    out_ready = 1'b1;
    checks++;
    if (k != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: sent=%0d pending=%0d expected 8 0", k, q.size());
    end
  endtask

  task automatic test_saturation_clear();
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (clean_cnt !== 2'd0 || corr_cnt !== 2'd0) begin
      errors++;
      $display("FAIL clr_idle: got %0d %0d expected 0 0", clean_cnt, corr_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      set_word(4'(i * 3), -1);
    end
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (clean_cnt !== 2'd3) begin
      errors++;
      $display("FAIL clean_saturate: clean_cnt=%0d expected 3", clean_cnt);
    end
    set_word(4'hA, -1);
    tick();
    in_valid = 1'b0;
    tick();
    cnt_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: out_valid=%b expected 1", out_valid);
    end
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (clean_cnt !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: clean_cnt=%0d v=%b expected 0 0", clean_cnt, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    tick();
    set_word(4'h6, 3);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    set_word(4'h3, -1);
    tick();
    set_word(4'h9, 4);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || corr_cnt !== 2'd1) begin
      errors++;
      $display("FAIL rst_mid_setup: rdy=%b v=%b corr=%0d expected 0 1 1", in_ready, out_valid, corr_cnt);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_err_pos !== 3'd7 ||
        clean_cnt !== 2'd0 || corr_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_state: v=%b rdy=%b pos=%0d clean=%0d corr=%0d expected 0 1 7 0 0",
               out_valid, in_ready, out_err_pos, clean_cnt, corr_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_drop: held words appeared %0d times expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_back_to_back();
    test_backpressure();
    test_saturation_clear();
    test_reset_mid();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
